// File: rtl/scan_dff_bank.sv
`default_nettype none
// ============================================================================
// scan_dff_bank : bank of mux-scan flops in CHAINS chains of LEN bits, with
//                 saturating shift counter and optional MISR compaction.
// Revision      : 1.0
// ============================================================================
module scan_dff_bank #(
    parameter int                CHAINS = 2,
    parameter int                LEN    = 4,
    parameter int                SIG_W  = 16,
    parameter logic [SIG_W-1:0]  POLY   = 16'h002D,
    parameter int                CNT_W  = $clog2(LEN + 1)
) (
    input  logic                     CK,
    input  logic                     RST,
    input  logic                     EN,
    input  logic                     SE,
    input  logic [CHAINS*LEN-1:0]    D,
    input  logic [CHAINS-1:0]        SI,
    output logic [CHAINS*LEN-1:0]    Q,
    output logic [CHAINS-1:0]        SO,
    input  logic                     MISR_EN,
    input  logic                     MISR_CLR,
    output logic [SIG_W-1:0]         SIG,
    output logic [CNT_W-1:0]         SHIFT_CNT,
    output logic                     SHIFT_DONE
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(LEN);

    logic [CHAINS*LEN-1:0] r_q;
    logic [CHAINS*LEN-1:0] w_q_shift;
    logic [SIG_W-1:0]      r_sig;
    logic [SIG_W-1:0]      w_so_ext;
    logic [SIG_W-1:0]      w_sig_next;
    logic [CNT_W-1:0]      r_cnt;
    logic                  w_shift;
    logic                  w_capture;

    if (CHAINS < 1 || CHAINS > SIG_W) begin : g_bad_chains
        $error("scan_dff_bank: CHAINS must be in 1..SIG_W");
    end
    if (LEN < 1) begin : g_bad_len
        $error("scan_dff_bank: LEN must be >= 1");
    end
    if (SIG_W < 2) begin : g_bad_sig_w
        $error("scan_dff_bank: SIG_W must be >= 2");
    end

    assign w_shift   = EN & SE;
    assign w_capture = EN & ~SE;

    for (genvar c = 0; c < CHAINS; c++) begin : g_chain
        if (LEN == 1) begin : g_len1
            assign w_q_shift[c] = SI[c];
        end else begin : g_lenn
            assign w_q_shift[c*LEN +: LEN] = {r_q[c*LEN +: LEN-1], SI[c]};
        end
        assign SO[c] = r_q[c*LEN + LEN - 1];
    end

    // Signature folds in the scan-out bits present before the shifting edge.
    always_comb begin
        w_so_ext               = '0;
        w_so_ext[CHAINS-1:0]   = SO;
        w_sig_next             = {r_sig[SIG_W-2:0], 1'b0}
                               ^ (r_sig[SIG_W-1] ? POLY : '0)
                               ^ w_so_ext;
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            r_q   <= '0;
            r_cnt <= '0;
        end else if (w_shift) begin
            r_q <= w_q_shift;
            if (r_cnt != C_CNT_MAX) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (w_capture) begin
            r_q   <= D;
            r_cnt <= '0;
        end
    end

    always_ff @(posedge CK) begin
        if (RST || MISR_CLR) begin
            r_sig <= '0;
        end else if (w_shift && MISR_EN) begin
            r_sig <= w_sig_next;
        end
    end

    assign Q          = r_q;
    assign SIG        = r_sig;
    assign SHIFT_CNT  = r_cnt;
    assign SHIFT_DONE = (r_cnt == C_CNT_MAX);

endmodule
`default_nettype wire

// File: tb/tb_scan_dff_bank.sv
`default_nettype none
// Testbench for scan_dff_bank: vector table on two 2x4 banks (16-bit and
// 4-bit MISR) plus a short sequence on a 1x1 bank, checked via scoreboards.
module tb_scan_dff_bank;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the two CHAINS=2, LEN=4 instances
    logic       rst, en, se, men, mclr;
    logic [7:0] d;
    logic [1:0] si;

    logic [7:0]  q_a, q_b;
    logic [1:0]  so_a, so_b;
    logic [15:0] sig_a;
    logic [3:0]  sig_b;
    logic [2:0]  cnt_a, cnt_b;
    logic        done_a, done_b;

    // Stimulus and outputs for the CHAINS=1, LEN=1 instance
    logic        rst_c, en_c, se_c, men_c, mclr_c;
    logic [0:0]  d_c, si_c, q_c, so_c, cnt_c;
    logic [15:0] sig_c;
    logic        done_c;

    scan_dff_bank dut_a (
        .CK(clk), .RST(rst), .EN(en), .SE(se), .D(d), .SI(si), .Q(q_a), .SO(so_a),
        .MISR_EN(men), .MISR_CLR(mclr), .SIG(sig_a), .SHIFT_CNT(cnt_a), .SHIFT_DONE(done_a)
    );

    scan_dff_bank #(.SIG_W(4), .POLY(4'h3)) dut_b (
        .CK(clk), .RST(rst), .EN(en), .SE(se), .D(d), .SI(si), .Q(q_b), .SO(so_b),
        .MISR_EN(men), .MISR_CLR(mclr), .SIG(sig_b), .SHIFT_CNT(cnt_b), .SHIFT_DONE(done_b)
    );

    scan_dff_bank #(.CHAINS(1), .LEN(1)) dut_c (
        .CK(clk), .RST(rst_c), .EN(en_c), .SE(se_c), .D(d_c), .SI(si_c), .Q(q_c), .SO(so_c),
        .MISR_EN(men_c), .MISR_CLR(mclr_c), .SIG(sig_c), .SHIFT_CNT(cnt_c), .SHIFT_DONE(done_c)
    );

    typedef struct {
        logic        rst, en, se;
        logic [7:0]  d;
        logic [1:0]  si;
        logic        men, mclr;
        logic [7:0]  q;
        logic [2:0]  cnt;
        logic [15:0] sig_a;
        logic [3:0]  sig_b;
    } vec_t;

    typedef struct {
        logic [7:0]  q;
        logic [1:0]  so;
        logic [2:0]  cnt;
        logic        done;
        logic [15:0] sig_a;
        logic [3:0]  sig_b;
    } exp_t;

    typedef struct {
        logic        rst, en, se, d, si;
        logic        q, so, cnt, done;
    } vec_c_t;

    vec_t   tbl[$];
    vec_c_t tbl_c[$];
    exp_t   sb[$];
    vec_c_t sb_c[$];

    int n_vec = 0;
    int n_err = 0;

    function automatic vec_t mk(logic r, logic e, logic s, logic [7:0] dd, logic [1:0] ss,
                                logic me, logic mc, logic [7:0] eq, logic [2:0] ec,
                                logic [15:0] esa, logic [3:0] esb);
        vec_t v;
        v.rst = r; v.en = e; v.se = s; v.d = dd; v.si = ss; v.men = me; v.mclr = mc;
        v.q = eq; v.cnt = ec; v.sig_a = esa; v.sig_b = esb;
        return v;
    endfunction

    function automatic vec_c_t mkc(logic r, logic e, logic s, logic dd, logic ss,
                                   logic eq, logic ec);
        vec_c_t v;
        v.rst = r; v.en = e; v.se = s; v.d = dd; v.si = ss;
        v.q = eq; v.so = eq; v.cnt = ec; v.done = ec;
        return v;
    endfunction

    task automatic chk(string name, int idx, logic [15:0] act, logic [15:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_ab(int idx);
        exp_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_ab[%0d]: got empty queue expected entry", idx);
            return;
        end
        e = sb.pop_front();
        chk("q_a",    idx, 16'(q_a),    16'(e.q));
        chk("so_a",   idx, 16'(so_a),   16'(e.so));
        chk("cnt_a",  idx, 16'(cnt_a),  16'(e.cnt));
        chk("done_a", idx, 16'(done_a), 16'(e.done));
        chk("sig_a",  idx, sig_a,       e.sig_a);
        chk("q_b",    idx, 16'(q_b),    16'(e.q));
        chk("cnt_b",  idx, 16'(cnt_b),  16'(e.cnt));
        chk("sig_b",  idx, 16'(sig_b),  16'(e.sig_b));
    endtask

    task automatic check_c(int idx);
        vec_c_t e;
        n_vec++;
        if (sb_c.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_c[%0d]: got empty queue expected entry", idx);
            return;
        end
        e = sb_c.pop_front();
        chk("q_c",    idx, 16'(q_c),    16'(e.q));
        chk("so_c",   idx, 16'(so_c),   16'(e.so));
        chk("cnt_c",  idx, 16'(cnt_c),  16'(e.cnt));
        chk("done_c", idx, 16'(done_c), 16'(e.done));
        chk("sig_c",  idx, sig_c,       16'h0000);
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; en = 1'b0; se = 1'b0; d = '0; si = '0; men = 1'b0; mclr = 1'b0;
        rst_c = 1'b1; en_c = 1'b0; se_c = 1'b0; d_c = '0; si_c = '0; men_c = 1'b0; mclr_c = 1'b0;

        //              rst en se  d      si     men mclr  q      cnt sig_a     sig_b
        tbl.push_back(mk(1, 1, 1, 8'hFF, 2'b11, 1, 0,  8'h00, 0, 16'h0000, 4'h0)); // reset wins
        tbl.push_back(mk(0, 1, 0, 8'hA5, 2'b00, 0, 0,  8'hA5, 0, 16'h0000, 4'h0)); // capture
        tbl.push_back(mk(0, 1, 1, 8'h00, 2'b00, 0, 0,  8'h4A, 1, 16'h0000, 4'h0));
        tbl.push_back(mk(0, 1, 1, 8'h00, 2'b00, 0, 0,  8'h84, 2, 16'h0000, 4'h0));
        tbl.push_back(mk(0, 1, 1, 8'h00, 2'b00, 0, 0,  8'h08, 3, 16'h0000, 4'h0));
        tbl.push_back(mk(0, 1, 1, 8'h00, 2'b00, 0, 0,  8'h00, 4, 16'h0000, 4'h0));
        tbl.push_back(mk(0, 1, 1, 8'h00, 2'b00, 0, 0,  8'h00, 4, 16'h0000, 4'h0)); // saturate
        tbl.push_back(mk(0, 1, 0, 8'h0C, 2'b00, 0, 0,  8'h0C, 0, 16'h0000, 4'h0));
        tbl.push_back(mk(0, 1, 1, 8'h00, 2'b00, 1, 0,  8'h08, 1, 16'h0001, 4'h1)); // MISR
        tbl.push_back(mk(0, 1, 1, 8'h00, 2'b00, 1, 0,  8'h00, 2, 16'h0003, 4'h3));
        tbl.push_back(mk(0, 0, 1, 8'h5A, 2'b11, 1, 0,  8'h00, 2, 16'h0003, 4'h3)); // hold
        tbl.push_back(mk(0, 0, 1, 8'hC3, 2'b01, 1, 0,  8'h00, 2, 16'h0003, 4'h3));
        tbl.push_back(mk(0, 0, 1, 8'h77, 2'b10, 1, 0,  8'h00, 2, 16'h0003, 4'h3));
        tbl.push_back(mk(0, 1, 0, 8'hF0, 2'b00, 1, 0,  8'hF0, 0, 16'h0003, 4'h3)); // capture keeps SIG
        tbl.push_back(mk(0, 1, 1, 8'h00, 2'b00, 1, 1,  8'hE0, 1, 16'h0000, 4'h0)); // clear + shift
        tbl.push_back(mk(0, 1, 1, 8'h00, 2'b00, 1, 0,  8'hC0, 2, 16'h0002, 4'h2));
        tbl.push_back(mk(0, 1, 1, 8'h00, 2'b00, 1, 0,  8'h80, 3, 16'h0006, 4'h6));
        tbl.push_back(mk(0, 1, 1, 8'h00, 2'b00, 1, 0,  8'h00, 4, 16'h000E, 4'hE));
        tbl.push_back(mk(0, 1, 1, 8'h00, 2'b00, 1, 0,  8'h00, 4, 16'h001C, 4'hF)); // POLY feedback
        tbl.push_back(mk(0, 1, 1, 8'h00, 2'b00, 1, 0,  8'h00, 4, 16'h0038, 4'hD));
        tbl.push_back(mk(0, 0, 0, 8'hFF, 2'b11, 1, 1,  8'h00, 4, 16'h0000, 4'h0)); // clear while EN=0
        tbl.push_back(mk(0, 1, 0, 8'h3C, 2'b00, 0, 0,  8'h3C, 0, 16'h0000, 4'h0));
        tbl.push_back(mk(0, 1, 1, 8'h00, 2'b11, 1, 0,  8'h79, 1, 16'h0001, 4'h1));
        tbl.push_back(mk(0, 1, 1, 8'h00, 2'b11, 1, 0,  8'hF3, 2, 16'h0003, 4'h3));
        tbl.push_back(mk(1, 1, 1, 8'h00, 2'b11, 1, 0,  8'h00, 0, 16'h0000, 4'h0)); // reset mid-shift
        tbl.push_back(mk(0, 1, 1, 8'h00, 2'b11, 0, 0,  8'h11, 1, 16'h0000, 4'h0));
        tbl.push_back(mk(0, 1, 1, 8'h00, 2'b11, 0, 0,  8'h33, 2, 16'h0000, 4'h0));
        tbl.push_back(mk(0, 1, 1, 8'h00, 2'b11, 0, 0,  8'h77, 3, 16'h0000, 4'h0));
        tbl.push_back(mk(0, 1, 1, 8'h00, 2'b11, 0, 0,  8'hFF, 4, 16'h0000, 4'h0));

        //                 rst en se d  si   q  cnt
        tbl_c.push_back(mkc(1, 1, 1, 1, 1,   0, 0));
        tbl_c.push_back(mkc(0, 1, 1, 0, 1,   1, 1));
        tbl_c.push_back(mkc(0, 1, 1, 1, 0,   0, 1)); // counter saturates at 1
        tbl_c.push_back(mkc(0, 1, 0, 1, 0,   1, 0));
        tbl_c.push_back(mkc(0, 1, 0, 0, 1,   0, 0));
        tbl_c.push_back(mkc(0, 0, 1, 1, 1,   0, 0)); // hold

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst = tbl[i].rst; en = tbl[i].en; se = tbl[i].se; d = tbl[i].d;
            si = tbl[i].si; men = tbl[i].men; mclr = tbl[i].mclr;
            e.q = tbl[i].q; e.so = {tbl[i].q[7], tbl[i].q[3]};
            e.cnt = tbl[i].cnt; e.done = (tbl[i].cnt == 3'd4);
            e.sig_a = tbl[i].sig_a; e.sig_b = tbl[i].sig_b;
            sb.push_back(e);
            @(posedge clk);
            #1;
            check_ab(i);
        end

        for (int i = 0; i < tbl_c.size(); i++) begin
            @(negedge clk);
            rst_c = tbl_c[i].rst; en_c = tbl_c[i].en; se_c = tbl_c[i].se;
            d_c = tbl_c[i].d; si_c = tbl_c[i].si;
            sb_c.push_back(tbl_c[i]);
            @(posedge clk);
            #1;
            check_c(i);
        end

        if (sb.size() != 0 || sb_c.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size() + sb_c.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
